lc3_mem_responder: RTL

LC3_MEM_RESPONDER -- requirements
Module: lc3_mem_responder

---
 rtl/lc3_mem_responder.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder
//   Single-port word memory responder for an LC-3 core. It accepts one access
//   at a time, inserts WAIT_CYCLES wait states, then pulses rsp_valid for one
//   cycle. Stores are written on the edge entering RESP. Loads read the RAM
//   during the RESP cycle.
//
//   Optional feature macro: LC3_MEM_MMIO_EN
//     When defined, FE00 (KBSR), FE02 (KBDR), FE04 (DSR) and FE06 (DDR) are
//     keyboard/display device registers. When undefined, those addresses are
//     ordinary aliased RAM and the device outputs are held at 0.
//
//   Ports
//     clk, rst_n            clock, synchronous active-low reset
//     req_valid/req_ready   access handshake (ready only in IDLE)
//     req_we                1 = store, 0 = load/fetch
//     req_addr, req_wdata   word address and store data
//     rsp_valid, rsp_rdata  one-cycle completion pulse and load data
//     kbd_valid, kbd_data   keyboard character strobe and character
//     dsp_ready             display idle
//     dsp_valid, dsp_data   display character strobe and character
//
//   state  | meaning
//   -------+--------------------------------------------------
//   S_IDLE | ready for a new access
//   S_WAIT | wait states; r_cnt counts down to 0
//   S_RESP | rsp_valid pulse; store already committed
module lc3_mem_responder #(
    parameter int AW          = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    input  logic        dsp_ready,
    output logic        dsp_valid,
    output logic [7:0]  dsp_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0]  WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
    localparam logic [15:0] ADDR_KBSR  = 16'hFE00;
    localparam logic [15:0] ADDR_KBDR  = 16'hFE02;
    localparam logic [15:0] ADDR_DSR   = 16'hFE04;
    localparam logic [15:0] ADDR_DDR   = 16'hFE06;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic        r_we;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_mem [2**AW];

    logic        w_accept;
    logic        w_enter_resp;
    logic        w_acc_we;
    logic [15:0] w_acc_addr;
    logic [15:0] w_acc_wdata;
    logic        w_acc_dev;
    logic [15:0] w_ram_rdata;
    logic [15:0] w_load_data;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                rsp_valid   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 16'h0000;
            r_wdata <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end
        end
    end

    // With zero wait states RESP is entered straight from IDLE, so the
    // store being committed is still on the request bus, not yet latched.
    assign w_enter_resp = (w_state_nxt == S_RESP);
    assign w_acc_we     = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_acc_addr   = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_acc_wdata  = (r_state == S_IDLE) ? req_wdata : r_wdata;

    // RAM is not cleared by reset. A reset at the commit edge drops the store.
    always_ff @(posedge clk) begin
        if (rst_n && w_enter_resp && w_acc_we && !w_acc_dev) begin
            r_mem[w_acc_addr[AW-1:0]] <= w_acc_wdata;
        end
    end

    assign w_ram_rdata = r_mem[r_addr[AW-1:0]];
    assign rsp_rdata   = (rsp_valid && !r_we) ? w_load_data : 16'h0000;

`ifdef LC3_MEM_MMIO_EN
    logic       r_kbd_pend;
    logic [7:0] r_kbd_data;

    assign w_acc_dev = (w_acc_addr == ADDR_KBSR) || (w_acc_addr == ADDR_KBDR) ||
                       (w_acc_addr == ADDR_DSR)  || (w_acc_addr == ADDR_DDR);

    // A new keyboard strobe takes priority over the KBDR read that clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_kbd_pend <= 1'b0;
            r_kbd_data <= 8'h00;
        end else if (kbd_valid) begin
            r_kbd_pend <= 1'b1;
            r_kbd_data <= kbd_data;
        end else if (rsp_valid && !r_we && (r_addr == ADDR_KBDR)) begin
            r_kbd_pend <= 1'b0;
        end
    end

    always_comb begin
        case (r_addr)
            ADDR_KBSR: w_load_data = {r_kbd_pend, 15'h0000};
            ADDR_KBDR: w_load_data = {8'h00, r_kbd_data};
            ADDR_DSR:  w_load_data = {dsp_ready, 15'h0000};
            ADDR_DDR:  w_load_data = 16'h0000;
            default:   w_load_data = w_ram_rdata;
        endcase
    end

    assign dsp_valid = rsp_valid && r_we && (r_addr == ADDR_DDR);
    assign dsp_data  = dsp_valid ? r_wdata[7:0] : 8'h00;
`else
    logic w_unused;

    assign w_acc_dev   = 1'b0;
    assign w_load_data = w_ram_rdata;
    assign dsp_valid   = 1'b0;
    assign dsp_data    = 8'h00;
    assign w_unused    = ^{kbd_valid, kbd_data, dsp_ready, r_addr, w_acc_addr,
                           ADDR_KBSR, ADDR_KBDR, ADDR_DSR, ADDR_DDR};
`endif

endmodule
